// File: rtl/acc_pool_pkg.sv
// Shared types and width helpers for the accumulate / ReLU / pool engine.
package acc_pool_pkg;

    typedef enum logic [1:0] {
        POOL_BYPASS = 2'd0,
        POOL_MAX    = 2'd1,
        POOL_AVG    = 2'd2
    } pool_mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    // Sized so that MAX_CH signed partial sums can never overflow.
    function automatic int acc_width(input int psum_w, input int max_ch);
        return psum_w + $clog2(max_ch);
    endfunction

    function automatic int rb_addr_width(input int max_ofmap);
        return (max_ofmap / 2 > 1) ? $clog2(max_ofmap / 2) : 1;
    endfunction

endpackage

// File: rtl/acc_lane.sv
// One output-channel lane: channel accumulation, ReLU + requantisation,
// 2x2 max/avg pooling with an even-row pair buffer, and the output data register.
module acc_lane
    import acc_pool_pkg::*;
#(
    parameter int PSUM_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_CH     = 64,
    parameter int MAX_OFMAP  = 32
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  beat,
    input  logic                                  first_ch,
    input  logic                                  last_ch,
    input  logic                                  row_odd,
    input  logic                                  col_odd,
    input  logic                                  pool_en,
    input  logic                                  avg_mode,
    input  logic                                  emit,
    input  logic [4:0]                            shift,
    input  logic [rb_addr_width(MAX_OFMAP)-1:0]   rb_addr,
    input  logic [PSUM_WIDTH-1:0]                 psum,
    output logic [DATA_WIDTH-1:0]                 out_data
);

    localparam int ACC_W    = acc_width(PSUM_WIDTH, MAX_CH);
    localparam int EXT_W    = ACC_W + DATA_WIDTH;
    localparam int RB_DEPTH = (MAX_OFMAP / 2 > 1) ? MAX_OFMAP / 2 : 2;
    localparam logic [DATA_WIDTH-1:0] PIX_MAX = '1;

    logic signed [ACC_W-1:0] psum_ext;
    logic signed [ACC_W-1:0] acc_sum;
    logic signed [ACC_W-1:0] acc_reg;
    logic [EXT_W-1:0]        relu_ext;
    logic [EXT_W-1:0]        shifted;
    logic [DATA_WIDTH-1:0]   pix;
    logic [DATA_WIDTH-1:0]   hold_reg;
    logic [DATA_WIDTH:0]     pair;
    logic [DATA_WIDTH+1:0]   quad_sum;
    logic [DATA_WIDTH-1:0]   pooled;
    logic [DATA_WIDTH-1:0]   result;
    logic [DATA_WIDTH-1:0]   out_data_reg;
    logic [DATA_WIDTH:0]     rd_data_reg;
    logic [DATA_WIDTH:0]     row_buf [RB_DEPTH];
    logic                    pix_done;

    assign psum_ext = {{(ACC_W-PSUM_WIDTH){psum[PSUM_WIDTH-1]}}, psum};
    assign acc_sum  = (first_ch ? '0 : acc_reg) + psum_ext;
    assign pix_done = beat && last_ch;

    // Shifts past the accumulator width naturally collapse to zero.
    assign relu_ext = acc_sum[ACC_W-1] ? '0 : {{DATA_WIDTH{1'b0}}, acc_sum};
    assign shifted  = relu_ext >> shift;
    assign pix      = (shifted > {{ACC_W{1'b0}}, PIX_MAX}) ? PIX_MAX : shifted[DATA_WIDTH-1:0];

    // Horizontal pair: max, or a 9-bit sum so the average keeps full precision.
    assign pair     = avg_mode ? ({1'b0, hold_reg} + {1'b0, pix})
                               : {1'b0, (hold_reg > pix) ? hold_reg : pix};
    assign quad_sum = {1'b0, pair} + {1'b0, rd_data_reg};
    assign pooled   = avg_mode ? quad_sum[DATA_WIDTH+1:2]
                               : ((pair > rd_data_reg) ? pair[DATA_WIDTH-1:0]
                                                       : rd_data_reg[DATA_WIDTH-1:0]);
    assign result   = pool_en ? pooled : pix;
    assign out_data = out_data_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_reg      <= '0;
            hold_reg     <= '0;
            out_data_reg <= '0;
        end else begin
            if (beat)
                acc_reg <= acc_sum;
            if (pix_done && !col_odd)
                hold_reg <= pix;
            if (emit)
                out_data_reg <= result;
        end
    end

    // Column address is stable across a 2-column pair, so the read issued
    // during the even column is ready when the odd column completes.
    always_ff @(posedge clk) begin
        if (pix_done && pool_en && !row_odd && col_odd)
            row_buf[rb_addr] <= pair;
        rd_data_reg <= row_buf[rb_addr];
    end

endmodule

// File: rtl/acc_relu_pool.sv
// Control for the multi-lane accumulate / ReLU / pool engine: config latch,
// channel and raster counters, output handshake and the IDLE/RUN/DRAIN FSM.
module acc_relu_pool
    import acc_pool_pkg::*;
#(
    parameter int LANES      = 16,
    parameter int PSUM_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_CH     = 64,
    parameter int MAX_OFMAP  = 32
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     start_i,
    input  logic [$clog2(MAX_CH+1)-1:0]              cfg_ch_num_i,
    input  logic [$clog2(MAX_OFMAP+1)-1:0]           cfg_ofmap_size_i,
    input  logic [4:0]                               cfg_shift_i,
    input  logic [1:0]                               cfg_pool_mode_i,
    input  logic                                     in_valid_i,
    output logic                                     in_ready_o,
    input  logic [LANES*PSUM_WIDTH-1:0]              psum_i,
    output logic                                     out_valid_o,
    input  logic                                     out_ready_i,
    output logic [LANES*DATA_WIDTH-1:0]              out_data_o,
    output logic [$clog2(MAX_OFMAP*MAX_OFMAP)-1:0]   out_addr_o,
    output logic                                     out_last_o,
    output logic                                     busy_o
);

    localparam int CH_W   = $clog2(MAX_CH + 1);
    localparam int SZ_W   = $clog2(MAX_OFMAP + 1);
    localparam int ADDR_W = $clog2(MAX_OFMAP * MAX_OFMAP);
    localparam int RB_AW  = rb_addr_width(MAX_OFMAP);

    state_e            state_reg;
    pool_mode_e        mode_reg;
    logic [CH_W-1:0]   ch_num_reg;
    logic [CH_W-1:0]   ch_cnt_reg;
    logic [SZ_W-1:0]   size_reg;
    logic [SZ_W-1:0]   col_reg;
    logic [SZ_W-1:0]   row_reg;
    logic [4:0]        shift_reg;
    logic [ADDR_W-1:0] out_idx_reg;
    logic [ADDR_W-1:0] out_addr_reg;
    logic              out_valid_reg;
    logic              out_last_reg;

    logic              beat;
    logic              first_ch;
    logic              last_ch;
    logic              last_col;
    logic              last_row;
    logic              pool_en;
    logic              avg_mode;
    logic              pix_done;
    logic              map_done;
    logic              emit;
    logic              final_out;
    logic [SZ_W-1:0]   pool_size;
    logic [RB_AW-1:0]  rb_addr;

    assign in_ready_o  = (state_reg == RUN) && (!out_valid_reg || out_ready_i);
    assign busy_o      = (state_reg != IDLE);
    assign out_valid_o = out_valid_reg;
    assign out_addr_o  = out_addr_reg;
    assign out_last_o  = out_last_reg;

    assign beat      = in_valid_i && in_ready_o;
    assign first_ch  = (ch_cnt_reg == '0);
    assign last_ch   = (ch_cnt_reg == ch_num_reg - CH_W'(1));
    assign last_col  = (col_reg == size_reg - SZ_W'(1));
    assign last_row  = (row_reg == size_reg - SZ_W'(1));
    assign pool_en   = (mode_reg == POOL_MAX) || (mode_reg == POOL_AVG);
    assign avg_mode  = (mode_reg == POOL_AVG);
    assign pix_done  = beat && last_ch;
    assign map_done  = pix_done && last_row && last_col;
    assign rb_addr   = RB_AW'(col_reg >> 1);

    // Odd sizes drop the trailing row/column, so the last pooled window ends
    // at the largest even size.
    assign pool_size = {size_reg[SZ_W-1:1], 1'b0};
    assign final_out = pool_en ? ((row_reg == pool_size - SZ_W'(1)) && (col_reg == pool_size - SZ_W'(1)))
                               : (last_row && last_col);
    assign emit      = pix_done && (!pool_en || (row_reg[0] && col_reg[0]));

    // Emissions occur in raster order of the output grid, so a running
    // count equals row*size+col (bypass) or the pooled-grid index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            mode_reg      <= POOL_BYPASS;
            ch_num_reg    <= '0;
            ch_cnt_reg    <= '0;
            size_reg      <= '0;
            col_reg       <= '0;
            row_reg       <= '0;
            shift_reg     <= '0;
            out_idx_reg   <= '0;
            out_addr_reg  <= '0;
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
        end else begin
            if (out_valid_reg && out_ready_i) begin
                out_valid_reg <= 1'b0;
                out_last_reg  <= 1'b0;
            end
            if (emit) begin
                out_valid_reg <= 1'b1;
                out_addr_reg  <= out_idx_reg;
                out_last_reg  <= final_out;
                out_idx_reg   <= out_idx_reg + ADDR_W'(1);
            end
            case (state_reg)
                IDLE: begin
                    if (start_i) begin
                        ch_num_reg  <= (cfg_ch_num_i == '0) ? CH_W'(1) : cfg_ch_num_i;
                        size_reg    <= (cfg_ofmap_size_i == '0) ? SZ_W'(1) : cfg_ofmap_size_i;
                        shift_reg   <= cfg_shift_i;
                        mode_reg    <= pool_mode_e'(cfg_pool_mode_i);
                        ch_cnt_reg  <= '0;
                        col_reg     <= '0;
                        row_reg     <= '0;
                        out_idx_reg <= '0;
                        state_reg   <= RUN;
                    end
                end
                RUN: begin
                    if (beat) begin
                        if (last_ch) begin
                            ch_cnt_reg <= '0;
                            if (last_col) begin
                                col_reg <= '0;
                                row_reg <= row_reg + SZ_W'(1);
                            end else begin
                                col_reg <= col_reg + SZ_W'(1);
                            end
                            if (map_done)
                                state_reg <= DRAIN;
                        end else begin
                            ch_cnt_reg <= ch_cnt_reg + CH_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (!out_valid_reg || out_ready_i)
                        state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            acc_lane #(
                .PSUM_WIDTH (PSUM_WIDTH),
                .DATA_WIDTH (DATA_WIDTH),
                .MAX_CH     (MAX_CH),
                .MAX_OFMAP  (MAX_OFMAP)
            ) u_lane (
                .clk      (clk),
                .rst      (rst),
                .beat     (beat),
                .first_ch (first_ch),
                .last_ch  (last_ch),
                .row_odd  (row_reg[0]),
                .col_odd  (col_reg[0]),
                .pool_en  (pool_en),
                .avg_mode (avg_mode),
                .emit     (emit),
                .shift    (shift_reg),
                .rb_addr  (rb_addr),
                .psum     (psum_i[gi*PSUM_WIDTH +: PSUM_WIDTH]),
                .out_data (out_data_o[gi*DATA_WIDTH +: DATA_WIDTH])
            );
        end
    endgenerate

endmodule

// File: doc/acc_relu_pool.md
ACC_RELU_POOL -- requirements
Module: acc_relu_pool

Interface
REQ-001 SHALL have parameter LANES, default 16, number of parallel output-channel lanes.
REQ-002 SHALL have parameter PSUM_WIDTH, default 8, signed partial-sum width per lane.
REQ-003 SHALL have parameter DATA_WIDTH, default 8, unsigned activation width.
REQ-004 SHALL have parameter MAX_CH, default 64, maximum input channels accumulated per pixel.
REQ-005 SHALL have parameter MAX_OFMAP, default 32, maximum ofmap side length.
REQ-006 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-007 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-008 SHALL have port start_i, input, 1, one-cycle pulse that latches configuration.
REQ-009 SHALL have ports cfg_ch_num_i [clog2(MAX_CH+1)], cfg_ofmap_size_i [clog2(MAX_OFMAP+1)], cfg_shift_i [5] and cfg_pool_mode_i [2], all inputs: channel count, ofmap side, requant right-shift and pool mode (0 bypass, 1 max 2x2, 2 avg 2x2).
REQ-010 SHALL have ports in_valid_i (input, 1), in_ready_o (output, 1) and psum_i (input, LANES x PSUM_WIDTH): partial-sum beat, one per lane.
REQ-011 SHALL have ports out_valid_o (output, 1), out_ready_i (input, 1), out_data_o (output, LANES x DATA_WIDTH), out_addr_o (output, clog2(MAX_OFMAP*MAX_OFMAP)) and out_last_o (output, 1).
REQ-012 SHALL have port busy_o, output, 1, high outside IDLE.

Function
REQ-013 SHALL implement states IDLE, RUN, DRAIN; start_i in IDLE latches cfg and enters RUN; start_i outside IDLE is ignored.
REQ-014 SHALL drive in_ready_o = (state==RUN) && (!out_valid_o || out_ready_i); a beat transfers when in_valid_i && in_ready_o.
REQ-015 SHALL use ACC_WIDTH = PSUM_WIDTH + clog2(MAX_CH) signed accumulators, which never overflow.
REQ-016 SHALL count channels 0..cfg_ch_num_i-1 per pixel: channel 0 loads sign-extended psum, later channels add; cfg_ch_num_i=0 is treated as 1.
REQ-017 SHALL on the last channel form pixel = min(max(acc,0) >> cfg_shift_i, 2^DATA_WIDTH-1) per lane; shift >= ACC_WIDTH yields 0.
REQ-018 SHALL advance col/row raster counters per completed pixel, wrapping col at cfg_ofmap_size_i.
REQ-019 SHALL in bypass mode emit every pixel with out_addr_o = row*size+col.
REQ-020 SHALL in pool modes keep a per-lane row buffer of depth MAX_OFMAP/2 holding the even-row horizontal pair result (max, or 9-bit sum for avg) and emit at odd row and odd col with out_addr_o = (row>>1)*(size>>1)+(col>>1).
REQ-021 SHALL compute avg as the 4-pixel sum >> 2, truncated.
REQ-022 SHALL, for odd cfg_ofmap_size_i in pool modes, discard the final column and row (floor).
REQ-023 SHALL register outputs: out_valid_o rises the cycle after the completing beat; out_data_o, out_addr_o and out_last_o stay stable until out_valid_o && out_ready_i.
REQ-024 SHALL assert out_last_o with the final output of the map, enter DRAIN, and return to IDLE once that output is accepted.

Reset
REQ-025 SHALL on rst clear state to IDLE, all counters and accumulators to 0, and out_valid_o, out_last_o, busy_o, in_ready_o, out_data_o and out_addr_o to 0; row-buffer contents need not clear.
REQ-026 SHALL abandon any in-progress map on rst mid-operation and accept a new start_i on the first cycle after release.

Structure
REQ-027 SHALL take pool_mode_e, state_e and the ACC_WIDTH function from shared package acc_pool_pkg.
REQ-028 SHALL implement one per-lane datapath sub-module acc_lane (accumulate, ReLU/requant, pool, row buffer), instantiated LANES times, with control in the top.

Verification
REQ-029 Bypass: size 4, ch 3, shift 0, psums 10,20,30 on all lanes -> 16 outputs of 60, addr 0..15, last on addr 15.
REQ-030 ReLU/saturation: ch 2, psums -100,-50 -> 0; psums 127,127, shift 0 -> 254; ch 4 x 127 -> 255.
REQ-031 Max pool: size 4, ch 1, pixel value = raster index -> 4 outputs 5,7,13,15 at addr 0..3.
REQ-032 Avg pool: same stimulus -> 2,4,10,12 (sums 10,18,42,50 >> 2); size 5 -> 4 outputs only, last on addr 3.
REQ-033 Backpressure: out_ready_i low 10 cycles mid-map -> in_ready_o low, output held stable, no loss or duplication.
REQ-034 Reset mid-map after 7 pixels -> all outputs 0 next edge; restart yields a fresh correct map.
